// File: rtl/apb_bus_arbiter.sv
// Two-master round-robin arbiter that sequences one SETUP/ACCESS bus transfer at a time.
// Latency: req seen in IDLE at t -> SETUP t+1 -> ACCESS t+2.. -> done pulse the cycle after ready/timeout.
// Backpressure: requesters hold req+payload until their done pulse; a slow slave stretches ACCESS up to TIMEOUT cycles.
//
// Ports:
//   pclk, presetn             clock and async active-low reset
//   mN_req/addr/wdata/write/stb  level request plus payload from master N (N = 0, 1)
//   mN_done/rdata/err         one-cycle completion pulse, with read data and error held until the next completion
//   paddr/pdata/pwrite/pstb   registered bus payload, held between transfers
//   psel/penable              bus phase strobes (SETUP: 1/0, ACCESS: 1/1)
//   prdata/ready/perr         slave response, only looked at during ACCESS
//   grant_id                  master owning the current or most recent transfer
module apb_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,

  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,

  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,

  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  ready,
  input  logic                  perr,

  output logic                  grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // TIMEOUT == 0 turns the abort path off entirely; CNT_WIDTH must be able
  // to represent TIMEOUT-1, the last count value before the abort fires.
  localparam bit                   TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;

  state_t                state;
  state_t                state_nxt;

  logic                  last_grant;   // 1 out of reset so m0 wins the first contention
  logic [CNT_WIDTH-1:0]  tmo_cnt;

  logic                  grant_go;     // IDLE is granting this cycle
  logic                  grant_sel;    // master being granted
  logic                  acc_ready;    // ACCESS finishing on slave ready
  logic                  acc_tmo;      // ACCESS finishing on timeout
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Next state, arbitration and phase outputs
  // --------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    grant_sel = 1'b0;
    acc_ready = 1'b0;
    acc_tmo   = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_go = 1'b1;
          // Under contention the master that did not go last wins; a lone
          // requester always wins regardless of history.
          if (m0_req && m1_req) begin
            grant_sel = ~last_grant;
          end else begin
            grant_sel = m1_req;
          end
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end

      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // ready is checked first so a response landing on the final
        // allowed cycle still completes normally.
        if (ready) begin
          acc_ready = 1'b1;
          state_nxt = DONE;
        end else if (TO_EN && (tmo_cnt == TO_LAST)) begin
          acc_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end

      DONE: begin
        m0_done   = ~grant_id;
        m1_done   = grant_id;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Response seen by the granted master: writes never return bus data, and
  // a timeout reports an error with zero data.
  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b1;
    if (acc_ready) begin
      rsp_data = pwrite ? '0 : prdata;
      rsp_err  = perr;
    end
  end

  // --------------------------------------------------------------------
  // Bus payload and grant bookkeeping; loaded only at grant so later
  // changes on the requester side do not disturb an ongoing transfer.
  // --------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr      <= '0;
      pdata      <= '0;
      pwrite     <= 1'b0;
      pstb       <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_go) begin
      paddr      <= grant_sel ? m1_addr  : m0_addr;
      pdata      <= grant_sel ? m1_wdata : m0_wdata;
      pwrite     <= grant_sel ? m1_write : m0_write;
      pstb       <= grant_sel ? m1_stb   : m0_stb;
      grant_id   <= grant_sel;
      last_grant <= grant_sel;
    end
  end

  // --------------------------------------------------------------------
  // ACCESS wait counter: zeroed in SETUP, counts ACCESS cycles that end
  // without ready.
  // --------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !acc_ready && !acc_tmo) begin
      tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------
  // Per-master response registers, written when ACCESS ends and held until
  // that master's next completion.
  // --------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else if (acc_ready || acc_tmo) begin
      if (grant_id) begin
        m1_rdata <= rsp_data;
        m1_err   <= rsp_err;
      end else begin
        m0_rdata <= rsp_data;
        m0_err   <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
module tb_apb_bus_arbiter;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_stb, m1_stb;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] paddr, pdata;
  logic [31:0] prdata = 32'h0;
  logic        psel, penable, pwrite, grant_id;
  logic [3:0]  pstb;
  logic        ready = 1'b0;
  logic        perr  = 1'b0;

  apb_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO), .CNT_WIDTH(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_stb(m0_stb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_stb(m1_stb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .ready(ready), .perr(perr), .grant_id(grant_id)
  );

  always #5 pclk = ~pclk;

  // ------------------------------------------------------------------
  // Slave: asserts ready in ACCESS cycle number sl_lat+1; outside ACCESS it
  // drives random noise on ready/perr/prdata that must be ignored.
  // ------------------------------------------------------------------
  int          sl_lat = 0;
  logic        sl_perr = 1'b0;
  logic [31:0] sl_prdata = 32'h0;
  int          acc = 0;

  always @(negedge pclk) begin
    if (psel && penable) begin
      ready  = (acc == sl_lat);
      perr   = ready ? sl_perr : 1'($urandom);
      prdata = ready ? sl_prdata : $urandom;
      acc    = acc + 1;
    end else begin
      acc    = 0;
      ready  = 1'($urandom);
      perr   = 1'($urandom);
      prdata = $urandom;
    end
  end

  // ------------------------------------------------------------------
  // Checking infrastructure and model state
  // ------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  int          last;          // master granted most recently
  int          wait_exp;      // negedges from request setup to SETUP
  logic [31:0] hrd [2];       // held rdata per master
  logic        her [2];       // held err per master

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic rq, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_req = rq; m0_write = wr; m0_addr = a; m0_wdata = d; m0_stb = s;
    end else begin
      m1_req = rq; m1_write = wr; m1_addr = a; m1_wdata = d; m1_stb = s;
    end
  endtask

  // Follows one transfer from the request negedge to its DONE negedge.
  task automatic run_txn(input string nm, input int id, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int cyc, input logic [31:0] rd, input logic er,
                         input logic scr, input logic drop);
    int   w;
    int   n;
    logic early;
    w = 0;
    early = 1'b0;
    do begin
      @(negedge pclk);
      w++;
      if (m0_done || m1_done) early = 1'b1;
    end while (!psel && w < 4);
    chk({nm, ".setup_wait"}, 32'(w), 32'(wait_exp));
    chk({nm, ".setup_penable"}, 32'(penable), 32'h0);
    chk({nm, ".paddr"}, paddr, a);
    chk({nm, ".pdata"}, pdata, d);
    chk({nm, ".pwrite"}, 32'(pwrite), 32'(wr));
    chk({nm, ".pstb"}, 32'(pstb), 32'(s));
    chk({nm, ".grant_id"}, 32'(grant_id), 32'(id));
    if (scr) set_m(id, 1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
    if (drop) begin
      if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
    n = 0;
    @(negedge pclk);
    while (psel && penable && n < 40) begin
      n++;
      if (m0_done || m1_done) early = 1'b1;
      @(negedge pclk);
    end
    chk({nm, ".access_cycles"}, 32'(n), 32'(cyc));
    chk({nm, ".early_done"}, 32'(early), 32'h0);
    chk({nm, ".done_psel"}, 32'({psel, penable}), 32'h0);
    chk({nm, ".own_done"}, 32'(id == 1 ? m1_done : m0_done), 32'h1);
    chk({nm, ".other_done"}, 32'(id == 1 ? m0_done : m1_done), 32'h0);
    hrd[id] = rd;
    her[id] = er;
    last    = id;
    chk({nm, ".m0_rdata"}, m0_rdata, hrd[0]);
    chk({nm, ".m0_err"}, 32'(m0_err), 32'(her[0]));
    chk({nm, ".m1_rdata"}, m1_rdata, hrd[1]);
    chk({nm, ".m1_err"}, 32'(m1_err), 32'(her[1]));
    chk({nm, ".paddr_hold"}, paddr, a);
    wait_exp = 2;
  endtask

  // ------------------------------------------------------------------
  // Directed vectors
  // ------------------------------------------------------------------
  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    int          lat;
    logic        sperr;
    logic [31:0] sprd;
    int          eid, ecyc;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  // Random-phase requester state
  logic        rq [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rdd[2];
  logic [3:0]  rs [2];

  task automatic new_payload(input int m);
    rq[m]  = 1'b1;
    rw[m]  = 1'($urandom);
    ra[m]  = $urandom & 32'hFFFF_FFFC;
    rdd[m] = $urandom;
    rs[m]  = 4'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Both masters contend for rows 0-3 straight out of reset: m0,m1,m0,m1.
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0, 32'h1000_0000,32'h1000_0004, 32'h41,32'h55, 4'hF,4'h1, 1, 1'b0,32'h1234_5678, 0, 2, 32'h0, 1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b0, 32'h1000_0000,32'h1000_0004, 32'h41,32'h55, 4'hF,4'h1, 0, 1'b0,32'hCAFE_0001, 1, 1, 32'hCAFE_0001, 1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0, 32'h2000_0010,32'h2000_0020, 32'h99,32'h77, 4'h3,4'hC, 2, 1'b0,32'h1111_2222, 0, 3, 32'h0, 1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b0, 32'h2000_0010,32'h2000_0020, 32'h99,32'h77, 4'h3,4'hC, 3, 1'b1,32'h0BAD_0BAD, 1, 4, 32'h0BAD_0BAD, 1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0, 32'h1000_0000,32'h0, 32'h41,32'h0, 4'hF,4'h0, 1, 1'b0,32'h5555_AAAA, 0, 2, 32'h0, 1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,32'h1000_0000, 32'h0,32'h0, 4'h0,4'hF, 1, 1'b1,32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 32'h1000_0008,32'h0, 32'h0,32'h0, 4'hF,4'h0, 100, 1'b0,32'h7777_7777, 0, 16, 32'h0, 1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, 32'h1000_000C,32'h0, 32'h0,32'h0, 4'hF,4'h0, 15, 1'b0,32'h600D_F00D, 0, 16, 32'h600D_F00D, 1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1, 32'h0,32'h1000_0010, 32'h0,32'hABCD, 4'h0,4'h3, 40, 1'b0,32'h4444_4444, 1, 16, 32'h0, 1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1, 32'h0,32'h1000_0014, 32'h0,32'h1357, 4'h0,4'h8, 0, 1'b1,32'hFFFF_FFFF, 1, 1, 32'h0, 1'b1};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0, 32'h3000_0000,32'h3000_0004, 32'h0,32'h0, 4'hF,4'hF, 2, 1'b0,32'h1357_2468, 0, 3, 32'h1357_2468, 1'b0};

    presetn = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    last = 1;
    hrd[0] = 32'h0; hrd[1] = 32'h0;
    her[0] = 1'b0;  her[1] = 1'b0;
    repeat (3) @(negedge pclk);

    // Reset state
    chk("rst.psel", 32'(psel), 32'h0);
    chk("rst.penable", 32'(penable), 32'h0);
    chk("rst.paddr", paddr, 32'h0);
    chk("rst.pdata", pdata, 32'h0);
    chk("rst.pwrite_pstb", 32'({pwrite, pstb}), 32'h0);
    chk("rst.done", 32'({m0_done, m1_done}), 32'h0);
    chk("rst.m0_rdata", m0_rdata, 32'h0);
    chk("rst.m1_rdata", m1_rdata, 32'h0);
    chk("rst.err", 32'({m0_err, m1_err}), 32'h0);
    chk("rst.grant_id", 32'(grant_id), 32'h0);

    @(negedge pclk);
    presetn  = 1'b1;
    wait_exp = 1;

    for (int i = 0; i < NV; i++) begin
      set_m(0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].s0);
      set_m(1, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].s1);
      sl_lat    = tbl[i].lat;
      sl_perr   = tbl[i].sperr;
      sl_prdata = tbl[i].sprd;
      run_txn($sformatf("vec%0d", i), tbl[i].eid,
              tbl[i].eid == 1 ? tbl[i].w1 : tbl[i].w0,
              tbl[i].eid == 1 ? tbl[i].a1 : tbl[i].a0,
              tbl[i].eid == 1 ? tbl[i].d1 : tbl[i].d0,
              tbl[i].eid == 1 ? tbl[i].s1 : tbl[i].s0,
              tbl[i].ecyc, tbl[i].erd, tbl[i].eerr, 1'b0, 1'b0);
    end

    // Granted master drops req and scrambles its payload after SETUP; the
    // transfer must still complete with the originally granted read.
    set_m(0, 1'b1, 1'b0, 32'h4000_0040, 32'h0, 4'hF);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sl_lat = 3; sl_perr = 1'b0; sl_prdata = 32'hA5A5_A5A5;
    run_txn("drop_scr", 0, 1'b0, 32'h4000_0040, 32'h0, 4'hF, 4, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1);

    // Reset pulsed during ACCESS of an m0 transfer.
    set_m(0, 1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'hF);
    sl_lat = 10;
    repeat (4) @(negedge pclk);
    chk("rst_mid.pre_access", 32'({psel, penable}), 32'h3);
    presetn = 1'b0;
    #1;
    chk("rst_mid.bus_drop", 32'({psel, penable}), 32'h0);
    chk("rst_mid.no_done", 32'({m0_done, m1_done}), 32'h0);
    chk("rst_mid.m0_rdata", m0_rdata, 32'h0);
    chk("rst_mid.errs", 32'({m0_err, m1_err}), 32'h0);
    hrd[0] = 32'h0; hrd[1] = 32'h0;
    her[0] = 1'b0;  her[1] = 1'b0;
    last = 1;
    set_m(0, 1'b1, 1'b0, 32'h5000_0100, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b0, 32'h5000_0200, 32'h0, 4'h1);
    sl_lat = 2; sl_perr = 1'b0; sl_prdata = 32'h0F0F_1234;
    @(negedge pclk);
    chk("rst_mid.no_done_hold", 32'({m0_done, m1_done}), 32'h0);
    presetn  = 1'b1;
    wait_exp = 1;
    run_txn("rst_mid.after", 0, 1'b0, 32'h5000_0100, 32'h0, 4'hF, 3, 32'h0F0F_1234, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the round-robin / timeout model.
    rq[0] = m0_req; rw[0] = m0_write; ra[0] = m0_addr; rdd[0] = m0_wdata; rs[0] = m0_stb;
    rq[1] = m1_req; rw[1] = m1_write; ra[1] = m1_addr; rdd[1] = m1_wdata; rs[1] = m1_stb;
    for (int it = 0; it < 150; it++) begin
      int          id;
      int          lat;
      int          cyc;
      logic        hit;
      logic [31:0] rd;
      logic        er;
      // Previous winner either re-requests with a new payload or goes quiet.
      if ($urandom_range(0, 1) == 1) new_payload(last); else rq[last] = 1'b0;
      if (!rq[1 - last] && $urandom_range(0, 1) == 1) new_payload(1 - last);
      if (!rq[0] && !rq[1]) new_payload(int'($urandom_range(0, 1)));
      set_m(0, rq[0], rw[0], ra[0], rdd[0], rs[0]);
      set_m(1, rq[1], rw[1], ra[1], rdd[1], rs[1]);

      id  = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
      lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(0, 15));
      sl_lat    = lat;
      sl_perr   = 1'($urandom);
      sl_prdata = $urandom;
      hit = (lat < TMO);
      cyc = hit ? lat + 1 : TMO;
      rd  = (hit && !rw[id]) ? sl_prdata : 32'h0;
      er  = hit ? sl_perr : 1'b1;
      run_txn($sformatf("rnd%0d", it), id, rw[id], ra[id], rdd[id], rs[id], cyc, rd, er,
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Two-requester arbiter and APB-style master sequencer for the shared peripheral bus (uart and future slaves).
- Accepts level-held transfer requests from two masters, m0 (CPU data port) and m1 (debug/loader).
- Grants one master at a time using round-robin and drives the SETUP/ACCESS bus phases.
- Returns read data and error to the granted master, and aborts with an error on slave timeout.

Parameters:
- ADDR_WIDTH, 32, width of address on requester and bus sides
- DATA_WIDTH, 32, width of read/write data
- TIMEOUT, 16, maximum ACCESS cycles without ready before abort; 0 disables the timeout
- CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT

Ports:
- pclk  in  1  clock; all logic on its rising edge
- presetn  in  1  asynchronous, active-low reset
- m0_req  in  1  m0 transfer request; level, held with stable payload until m0_done
- m0_addr  in  ADDR_WIDTH  m0 address
- m0_wdata  in  DATA_WIDTH  m0 write data
- m0_write  in  1  1=write, 0=read
- m0_stb  in  4  m0 byte strobes
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_done
- m0_err  out  1  error, valid with m0_done
- m1_req, m1_addr, m1_wdata, m1_write, m1_stb, m1_done, m1_rdata, m1_err: identical for m1
- paddr  out  ADDR_WIDTH  bus address
- pdata  out  DATA_WIDTH  bus write data
- prdata  in  DATA_WIDTH  bus read data
- psel  out  1  bus select
- penable  out  1  access phase
- pwrite  out  1  bus direction
- pstb  out  4  bus byte strobes
- ready  in  1  slave completion
- perr  in  1  slave error, sampled only with ready
- grant_id  out  1  master owning the current or last transfer

Behaviour:
Reset:
- presetn low asynchronously forces state IDLE.
- Clears psel, penable, pwrite, paddr, pdata, pstb, both done/rdata/err outputs, grant_id, timeout counter.
- Sets last-granted = 1, so m0 wins the first contention.

FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the master that is not last-granted.
  - On grant: register that master's addr/wdata/write/stb onto paddr/pdata/pwrite/pstb, set grant_id and last-granted, go to SETUP.
- SETUP (1 cycle): psel=1, penable=0. Next state ACCESS; clear the timeout counter.
- ACCESS:
  - psel=1, penable=1.
  - If ready=1: capture prdata (reads only; writes return 0) and perr into the granted master's rdata/err; go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: capture rdata=0, err=1; go to DONE.
  - Else: increment counter.
- DONE (1 cycle):
  - psel=0, penable=0.
  - Granted master's done=1 with rdata/err valid; the other master's done=0.
  - Next state IDLE unconditionally. The requester drops req on this edge, or holds it to issue a new transfer.

Output rules:
- paddr/pdata/pwrite/pstb hold their values outside transfers.
- mN_rdata/mN_err hold until that master's next completion.

Latency:
- req sampled in IDLE at cycle t → SETUP t+1 → ACCESS t+2.
- With a registered-ready slave, ready is seen at t+3 → done at t+4.
- Minimum request-to-request spacing is 5 cycles.

Boundary conditions:
- Requests are sampled only in IDLE.
- req deasserted mid-transfer is ignored; the transfer completes and done is still pulsed.
- ready arriving in the same cycle as the timeout expiry: ready wins (normal completion, err=perr).
- ready or perr outside ACCESS: ignored.
- Payload changes on the granted master after SETUP have no effect.
- Round-robin fairness: under continuous contention, grants alternate strictly.
- presetn asserted mid-transfer: the bus drops immediately, no done is issued, state returns to IDLE.

Test Plan:
- m0 write, addr=0x1000_0000, wdata=0x41, stb=0xF, uart-like slave → psel at t+1, penable at t+2, m0_done at t+4, m0_err=0, m1_done stays 0.
- m1 read, addr=0x1000_0000, slave returns prdata=0xDEAD_BEEF with perr=1 → m1_rdata=0xDEADBEEF, m1_err=1, one-cycle m1_done.
- Both req held high for 4 transfers after reset → grant order m0,m1,m0,m1; grant_id matches each done.
- Slave never asserts ready, TIMEOUT=16 → ACCESS lasts exactly 16 cycles, then done with err=1 and rdata=0; bus returns to psel=0.
- ready asserted on the 16th ACCESS cycle → normal completion, err=perr=0.
- presetn pulsed low during ACCESS → psel/penable 0 asynchronously, no done pulse; a fresh m0 req afterward completes normally with m0 granted first.
